// File: rtl/fp_pkg.sv
// Shared floating-point format constants and exponent-path flag bundle.
// Used by the multiplier and adder exponent datapaths.
package fp_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_BIAS  = 15;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_BIAS  = 127;
    localparam int FP64_EXP_W = 11;
    localparam int FP64_BIAS  = 1023;

    typedef struct packed {
        logic ovf;
        logic udf;
        logic special;
    } exp_flags_t;

endpackage

// File: rtl/exp_sat.sv
// Exponent select and classify: picks s or s+1, then saturates and flags.
// Purely combinational; shared by the multiplier and adder exponent paths.
module exp_sat
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int EMAX  = (1 << EXP_W) - 1
) (
    input  logic [EXP_W+1:0] i_sum,
    input  logic [EXP_W+1:0] i_sum1,
    input  logic             i_inc,
    input  logic             i_zero,
    input  logic             i_inf,
    output logic [EXP_W-1:0] o_exp,
    output exp_flags_t       o_flags
);

    localparam logic [EXP_W+1:0] EMAX_W = (EXP_W + 2)'(EMAX);
    localparam logic [EXP_W-1:0] EMAX_E = EXP_W'(EMAX);

    logic [EXP_W+1:0] w_r;
    logic             w_neg;
    logic             w_ovf;
    logic             w_udf;

    assign w_r   = i_inc ? i_sum1 : i_sum;
    assign w_neg = w_r[EXP_W+1];
    assign w_ovf = !w_neg && (w_r >= EMAX_W);
    assign w_udf = w_neg || (w_r == '0);

    always_comb begin
        o_exp   = w_r[EXP_W-1:0];
        o_flags = '0;
        if (i_inf) begin
            o_exp           = EMAX_E;
            o_flags.special = 1'b1;
        end else if (i_zero) begin
            o_exp           = '0;
            o_flags.special = 1'b1;
        end else if (w_ovf) begin
            o_exp       = EMAX_E;
            o_flags.ovf = 1'b1;
        end else if (w_udf) begin
            o_exp       = '0;
            o_flags.udf = 1'b1;
        end
    end

endmodule

// File: rtl/exp_add_pipe.sv
// Two-stage exponent path for the FP multiplier: expA + expB - BIAS + inc.
// Stage 1 forms s and s+1, stage 2 selects and saturates; valid/ready stall.
module exp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int BIAS  = (1 << (EXP_W - 1)) - 1,
    parameter int EMAX  = (1 << EXP_W) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] expA,
    input  logic [EXP_W-1:0] expB,
    input  logic             inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp,
    output logic             ovf,
    output logic             udf,
    output logic             special
);

    localparam int SW = EXP_W + 2;
    localparam logic [SW-1:0]    BIAS_W = SW'(BIAS);
    localparam logic [EXP_W-1:0] EMAX_E = EXP_W'(EMAX);

    typedef struct packed {
        logic [SW-1:0] sum;
        logic [SW-1:0] sum1;
        logic          inc;
        logic          za;
        logic          zb;
        logic          ia;
        logic          ib;
    } s1_t;

    logic             r_s1_valid;
    s1_t              r_s1;
    logic             r_s2_valid;
    logic [EXP_W-1:0] r_exp;
    exp_flags_t       r_flags;

    s1_t              w_s1_d;
    logic             w_adv1;
    logic             w_adv2;
    logic [EXP_W-1:0] w_exp;
    exp_flags_t       w_flags;

    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    // SW bits hold the full range, so s and s+1 never alias.
    always_comb begin
        w_s1_d.sum  = {2'b00, expA} + {2'b00, expB} - BIAS_W;
        w_s1_d.sum1 = w_s1_d.sum + SW'(1);
        w_s1_d.inc  = inc;
        w_s1_d.za   = (expA == '0);
        w_s1_d.zb   = (expB == '0);
        w_s1_d.ia   = (expA == EMAX_E);
        w_s1_d.ib   = (expB == EMAX_E);
    end

    exp_sat #(
        .EXP_W(EXP_W),
        .EMAX (EMAX)
    ) u_sat (
        .i_sum  (r_s1.sum),
        .i_sum1 (r_s1.sum1),
        .i_inc  (r_s1.inc),
        .i_zero (r_s1.za || r_s1.zb),
        .i_inf  (r_s1.ia || r_s1.ib),
        .o_exp  (w_exp),
        .o_flags(w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_exp      <= '0;
            r_flags    <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid) r_s1 <= w_s1_d;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_exp   <= w_exp;
                    r_flags <= w_flags;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign exp       = r_exp;
    assign ovf       = r_flags.ovf;
    assign udf       = r_flags.udf;
    assign special   = r_flags.special;

endmodule
